// File: rtl/mdu_if.sv
// Operand/result bundle between the EX stage and the multiply/divide unit.
interface mdu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wr_data;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs_data, rt_data, hi_we, lo_we, wr_data,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, rs_data, rt_data, hi_we, lo_we, wr_data,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with private HI/LO registers and mthi/mtlo writes.
// Optional MDU_FAST_MULT_EN: combinational multiply written at the start edge; divide stays iterative.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input logic   clk,
  input logic   rst,
  mdu_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DIV  = 2'b10,
    FIX  = 2'b11
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_res_q, neg_res_d;
  logic                 neg_rem_q, neg_rem_d;
  logic                 div_zero_q, div_zero_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;

  logic                 rs_neg_s, rt_neg_s;
  logic [WIDTH-1:0]     rs_mag_s, rt_mag_s;
  logic [WIDTH:0]       mul_sum_s;
  logic [WIDTH:0]       div_trial_s;
  logic [2*WIDTH-1:0]   prod_fix_s;
  logic [WIDTH-1:0]     quo_fix_s, rem_fix_s;
`ifdef MDU_FAST_MULT_EN
  logic [2*WIDTH-1:0]   fast_mag_s, fast_prod_s;
`endif

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

  // Operand preparation and per-step datapath arithmetic
  always_comb begin
    rs_neg_s    = ~bus.op[0] & bus.rs_data[WIDTH-1];
    rt_neg_s    = ~bus.op[0] & bus.rt_data[WIDTH-1];
    rs_mag_s    = magnitude(bus.rs_data, rs_neg_s);
    rt_mag_s    = magnitude(bus.rt_data, rt_neg_s);
    mul_sum_s   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : {WIDTH{1'b0}})};
    // Restoring step: shifted partial remainder can need WIDTH+1 bits before the subtract.
    div_trial_s = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opb_q};
    prod_fix_s  = neg_res_q ? (~acc_q + {{(2*WIDTH-1){1'b0}}, 1'b1}) : acc_q;
    rem_fix_s   = magnitude(acc_q[2*WIDTH-1:WIDTH], neg_rem_q);
    if (div_zero_q) begin
      quo_fix_s = {WIDTH{1'b1}};
    end else begin
      quo_fix_s = magnitude(acc_q[WIDTH-1:0], neg_res_q);
    end
`ifdef MDU_FAST_MULT_EN
    fast_mag_s  = {{WIDTH{1'b0}}, rs_mag_s} * {{WIDTH{1'b0}}, rt_mag_s};
    fast_prod_s = (rs_neg_s ^ rt_neg_s) ? (~fast_mag_s + {{(2*WIDTH-1){1'b0}}, 1'b1}) : fast_mag_s;
`endif
  end

  // FSM next-state, iteration and HI/LO update logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opb_d      = opb_q;
    is_div_d   = is_div_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    hi_d       = hi_q;
    lo_d       = lo_q;
    case (state_q)
      IDLE: begin
        if (!busy_q && bus.start) begin
          is_div_d   = bus.op[1];
          neg_res_d  = rs_neg_s ^ rt_neg_s;
          neg_rem_d  = rs_neg_s;
          div_zero_d = bus.op[1] & (bus.rt_data == {WIDTH{1'b0}});
          acc_d      = {{WIDTH{1'b0}}, rs_mag_s};
          opb_d      = rt_mag_s;
          cnt_d      = {CW{1'b0}};
`ifdef MDU_FAST_MULT_EN
          if (bus.op[1]) begin
            state_d = DIV;
            busy_d  = 1'b1;
          end else begin
            hi_d   = fast_prod_s[2*WIDTH-1:WIDTH];
            lo_d   = fast_prod_s[WIDTH-1:0];
            done_d = 1'b1;
          end
`else
          state_d = bus.op[1] ? DIV : MUL;
          busy_d  = 1'b1;
`endif
        end else if (!busy_q) begin
          if (bus.hi_we) begin
            hi_d = bus.wr_data;
          end else begin
            hi_d = hi_q;
          end
          if (bus.lo_we) begin
            lo_d = bus.wr_data;
          end else begin
            lo_d = lo_q;
          end
        end else begin
          state_d = IDLE;
        end
      end
      MUL: begin
        acc_d = {mul_sum_s, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH-1)) begin
          state_d = FIX;
        end else begin
          state_d = MUL;
        end
      end
      DIV: begin
        if (!div_trial_s[WIDTH]) begin
          acc_d = {div_trial_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH-1)) begin
          state_d = FIX;
        end else begin
          state_d = DIV;
        end
      end
      FIX: begin
        if (is_div_q) begin
          hi_d = rem_fix_s;
          lo_d = quo_fix_s;
        end else begin
          hi_d = prod_fix_s[2*WIDTH-1:WIDTH];
          lo_d = prod_fix_s[WIDTH-1:0];
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= {CW{1'b0}};
      acc_q      <= {(2*WIDTH){1'b0}};
      opb_q      <= {WIDTH{1'b0}};
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      hi_q       <= {WIDTH{1'b0}};
      lo_q       <= {WIDTH{1'b0}};
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opb_q      <= opb_d;
      is_div_q   <= is_div_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit (default build or MDU_FAST_MULT_EN).
module tb_mult_div_unit;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

`ifdef MDU_FAST_MULT_EN
  localparam int MUL_LAT  = 0;
  localparam logic MUL_BUSY = 1'b0;
`else
  localparam int MUL_LAT  = 33;
  localparam logic MUL_BUSY = 1'b1;
`endif
  localparam int DIV_LAT = 33;

  mdu_if #(.WIDTH(32)) bus ();
  mult_div_unit #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge; pulses start for one edge and waits (bounded) for done.
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic busy_seen);
    bus.op = o; bus.rs_data = a; bus.rt_data = b; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    busy_seen = bus.busy;
    lat = 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got %b exp 0", bus.done); end
    checks++; if (bus.hi !== 32'h0) begin failures++; $display("FAIL reset_hi got %h exp 0", bus.hi); end
    checks++; if (bus.lo !== 32'h0) begin failures++; $display("FAIL reset_lo got %h exp 0", bus.lo); end
    rst = 1'b0;
  endtask

  task automatic test_multiply();
    logic [1:0]  o_v  [4] = '{2'b01, 2'b00, 2'b00, 2'b01};
    logic [31:0] a_v  [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'h1234_5678};
    logic [31:0] b_v  [4] = '{32'h0000_0002, 32'h0000_0005, 32'hFFFF_FFFD, 32'h0000_0010};
    logic [31:0] hi_v [4] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    logic [31:0] lo_v [4] = '{32'hFFFF_FFFE, 32'hFFFF_FFF1, 32'h0000_0006, 32'h2345_6780};
    int lat;
    logic bsy;
    for (int i = 0; i < 4; i++) begin
      launch(o_v[i], a_v[i], b_v[i], lat, bsy);
      checks++; if (lat !== MUL_LAT) begin failures++; $display("FAIL mul_latency[%0d] got %0d exp %0d", i, lat, MUL_LAT); end
      checks++; if (bsy !== MUL_BUSY) begin failures++; $display("FAIL mul_busy[%0d] got %b exp %b", i, bsy, MUL_BUSY); end
      checks++; if (bus.hi !== hi_v[i]) begin failures++; $display("FAIL mul_hi[%0d] got %h exp %h", i, bus.hi, hi_v[i]); end
      checks++; if (bus.lo !== lo_v[i]) begin failures++; $display("FAIL mul_lo[%0d] got %h exp %h", i, bus.lo, lo_v[i]); end
      @(negedge clk);
      checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL mul_done_pulse[%0d] got %b exp 0", i, bus.done); end
      checks++; if (bus.hi !== hi_v[i] || bus.lo !== lo_v[i]) begin failures++; $display("FAIL mul_hold[%0d] got %h_%h exp %h_%h", i, bus.hi, bus.lo, hi_v[i], lo_v[i]); end
    end
  endtask

  task automatic test_divide();
    logic [1:0]  o_v  [6] = '{2'b10, 2'b11, 2'b11, 2'b10, 2'b10, 2'b10};
    logic [31:0] a_v  [6] = '{32'hFFFF_FFF9, 32'h0000_0064, 32'h0000_0064, 32'h8000_0000, 32'hFFFF_FFF9, 32'h0000_0007};
    logic [31:0] b_v  [6] = '{32'h0000_0002, 32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFE};
    logic [31:0] hi_v [6] = '{32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0064, 32'h0000_0000, 32'hFFFF_FFF9, 32'h0000_0001};
    logic [31:0] lo_v [6] = '{32'hFFFF_FFFD, 32'h0000_000E, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    int lat;
    logic bsy;
    for (int i = 0; i < 6; i++) begin
      launch(o_v[i], a_v[i], b_v[i], lat, bsy);
      checks++; if (lat !== DIV_LAT) begin failures++; $display("FAIL div_latency[%0d] got %0d exp %0d", i, lat, DIV_LAT); end
      checks++; if (bsy !== 1'b1) begin failures++; $display("FAIL div_busy[%0d] got %b exp 1", i, bsy); end
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL div_busy_at_done[%0d] got %b exp 0", i, bus.busy); end
      checks++; if (bus.hi !== hi_v[i]) begin failures++; $display("FAIL div_hi[%0d] got %h exp %h", i, bus.hi, hi_v[i]); end
      checks++; if (bus.lo !== lo_v[i]) begin failures++; $display("FAIL div_lo[%0d] got %h exp %h", i, bus.lo, lo_v[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_busy_ignore();
    int k;
    bus.op = 2'b11; bus.rs_data = 32'd100; bus.rt_data = 32'd7; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    k = 0;
    while (bus.done !== 1'b1 && k < 100) begin
      if (k == 3) begin
        bus.op = 2'b00; bus.rs_data = 32'd5; bus.rt_data = 32'd5; bus.start = 1'b1;
        bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wr_data = 32'hDEAD_BEEF;
      end else if (k == 4) begin
        bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    checks++; if (k !== DIV_LAT) begin failures++; $display("FAIL ignore_latency got %0d exp %0d", k, DIV_LAT); end
    checks++; if (bus.hi !== 32'd2 || bus.lo !== 32'd14) begin failures++; $display("FAIL ignore_result got %h_%h exp 00000002_0000000e", bus.hi, bus.lo); end
    @(negedge clk);
    bus.hi_we = 1'b1; bus.wr_data = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.hi_we = 1'b0;
    checks++; if (bus.hi !== 32'hDEAD_BEEF) begin failures++; $display("FAIL mthi got %h exp deadbeef", bus.hi); end
    checks++; if (bus.lo !== 32'd14) begin failures++; $display("FAIL mthi_lo_kept got %h exp 0000000e", bus.lo); end
    bus.lo_we = 1'b1; bus.wr_data = 32'h0BAD_F00D;
    @(negedge clk);
    bus.lo_we = 1'b0;
    checks++; if (bus.lo !== 32'h0BAD_F00D || bus.hi !== 32'hDEAD_BEEF) begin failures++; $display("FAIL mtlo got %h_%h exp deadbeef_0badf00d", bus.hi, bus.lo); end
  endtask

  task automatic test_simultaneous();
    int lat;
    logic bsy;
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wr_data = 32'h1111_1111;
    launch(2'b01, 32'd3, 32'd4, lat, bsy);
    bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    checks++; if (lat !== MUL_LAT) begin failures++; $display("FAIL start_wins_latency got %0d exp %0d", lat, MUL_LAT); end
    checks++; if (bus.hi !== 32'h0 || bus.lo !== 32'd12) begin failures++; $display("FAIL start_wins got %h_%h exp 00000000_0000000c", bus.hi, bus.lo); end
    @(negedge clk);
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wr_data = 32'h1234_5678;
    @(negedge clk);
    bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    checks++; if (bus.hi !== 32'h1234_5678 || bus.lo !== 32'h1234_5678) begin failures++; $display("FAIL both_writes got %h_%h exp 12345678_12345678", bus.hi, bus.lo); end
  endtask

  task automatic test_reset_abort();
    int lat;
    logic bsy;
    bus.op = 2'b11; bus.rs_data = 32'hFFFF_0000; bus.rt_data = 32'd3; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin failures++; $display("FAIL abort_flags got busy=%b done=%b exp 0 0", bus.busy, bus.done); end
    checks++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin failures++; $display("FAIL abort_hilo got %h_%h exp 0_0", bus.hi, bus.lo); end
    rst = 1'b0;
    launch(2'b11, 32'd100, 32'd7, lat, bsy);
    checks++; if (lat !== DIV_LAT) begin failures++; $display("FAIL abort_restart_latency got %0d exp %0d", lat, DIV_LAT); end
    checks++; if (bus.hi !== 32'd2 || bus.lo !== 32'd14) begin failures++; $display("FAIL abort_restart got %h_%h exp 00000002_0000000e", bus.hi, bus.lo); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat;
    logic bsy;
    launch(2'b00, 32'hFFFF_FFFD, 32'd5, lat, bsy);
    checks++; if (lat !== MUL_LAT || bus.lo !== 32'hFFFF_FFF1) begin failures++; $display("FAIL b2b_first got lat=%0d lo=%h exp lat=%0d lo=fffffff1", lat, bus.lo, MUL_LAT); end
    launch(2'b10, 32'hFFFF_FFF9, 32'd2, lat, bsy);
    checks++; if (lat !== DIV_LAT) begin failures++; $display("FAIL b2b_second_latency got %0d exp %0d", lat, DIV_LAT); end
    checks++; if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFD) begin failures++; $display("FAIL b2b_second got %h_%h exp ffffffff_fffffffd", bus.hi, bus.lo); end
    @(negedge clk);
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.op = 2'b00; bus.rs_data = 32'h0; bus.rt_data = 32'h0;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wr_data = 32'h0;
    test_reset();
    test_multiply();
    test_divide();
    test_busy_ignore();
    test_simultaneous();
    test_reset_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
